// File: rtl/pipe_hazard_ctl.sv
// Pipeline hazard controller: load-use stalls, taken control-transfer flushes,
// and data-memory wait states with a timeout abort.
module pipe_hazard_ctl #(
  parameter int TIMEOUT = 255,
  parameter int CNTW    = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [4:0]      ex_destReg,
  input  logic            ex_MemToReg,
  input  logic            ex_RegWrite,
  input  logic            ex_leap,
  input  logic            mem_req,
  input  logic            mem_ready,
  output logic            pc_hold,
  output logic            if_id_hold,
  output logic            id_ex_hold,
  output logic            ex_mem_hold,
  output logic            if_id_flush,
  output logic            id_ex_flush,
  output logic            mem_wb_flush,
  output logic            mem_err,
  output logic [CNTW-1:0] stall_cnt
);

  typedef enum logic {RUN, MEMWAIT} state_t;

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t     state, nextState;
  logic [7:0] timer, nextTimer;
  logic       pendFlush, nextPendFlush;
  logic       memStall, loadUse;

  assign memStall = mem_req & ~mem_ready;
  assign loadUse  = ex_MemToReg & ex_RegWrite & (ex_destReg != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_destReg)) |
                     (id_use_rs2 & (id_rs2 == ex_destReg)));

  // Registered control state; reset abandons any outstanding access and pending flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      timer     <= 8'd0;
      pendFlush <= 1'b0;
    end else begin
      state     <= nextState;
      timer     <= nextTimer;
      pendFlush <= nextPendFlush;
    end
  end

  // Stage controls are combinational and forced low while reset is held.
  always_comb begin
    nextState     = state;
    nextTimer     = timer;
    nextPendFlush = pendFlush;
    pc_hold       = 1'b0;
    if_id_hold    = 1'b0;
    id_ex_hold    = 1'b0;
    ex_mem_hold   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_flush  = 1'b0;
    mem_err       = 1'b0;
    if (reset) begin
      case (state)
        RUN: begin
          if (memStall) begin
            pc_hold       = 1'b1;
            if_id_hold    = 1'b1;
            id_ex_hold    = 1'b1;
            ex_mem_hold   = 1'b1;
            mem_wb_flush  = 1'b1;
            nextState     = MEMWAIT;
            nextTimer     = 8'd0;
            nextPendFlush = ex_leap;
          end else if (ex_leap) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (loadUse) begin
            pc_hold     = 1'b1;
            if_id_hold  = 1'b1;
            id_ex_flush = 1'b1;
          end
        end
        MEMWAIT: begin
          // A leap deferred behind the stall is applied on the release cycle.
          if (mem_ready || (timer == TIMER_LAST)) begin
            mem_err       = ~mem_ready;
            if_id_flush   = pendFlush;
            id_ex_flush   = pendFlush;
            nextPendFlush = 1'b0;
            nextState     = RUN;
            nextTimer     = 8'd0;
          end else begin
            pc_hold      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_hold   = 1'b1;
            ex_mem_hold  = 1'b1;
            mem_wb_flush = 1'b1;
            nextTimer    = timer + 8'd1;
          end
        end
        default: nextState = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (pc_hold && (stall_cnt != {CNTW{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
